jtag_dr_ctrl: RTL and testbench
===============================

Name: jtag_dr_ctrl

Overview:
- Sequences the user JTAG data register exposed by the FPGA boundary-scan TAP wrapper (tck/tdi/tdo plus capture/shift/update/reset strobes).
- Turns host scan operations into a byte-wide, JTAG-UART-style mailbox on the system clock.
- Owns all DR state: capture snapshot, shifting, and update command decode.
- Presents valid/ready byte streams to the system side; sits between the TAP wrapper and the CPU debug/UART logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on every TAP input (minimum 2).
- DATA_W, 8, payload width of the DR data field.
- CMD_W, 3, width of the DR command/status field; DR length = DATA_W+CMD_W (11).

Ports:
- clk_sys_i  in  1  system clock; the only clock. Must be at least 4x the tck frequency.
- rst_n_i  in  1  synchronous, active-low reset.
- jtag_tck_i  in  1  TAP data clock (treated as data, oversampled).
- jtag_tdi_i  in  1  TAP serial in.
- jtag_tdo_o  out  1  TAP serial out (registered, equals sr[0]).
- jtag_capture_i  in  1  capture-DR strobe (selected).
- jtag_shift_i  in  1  shift-DR level (selected).
- jtag_update_i  in  1  update-DR strobe.
- jtag_reset_i  in  1  TAP test-logic-reset.
- rx_data_o  out  DATA_W  byte written by the host.
- rx_valid_o  out  1  rx_data_o holds an unconsumed byte.
- rx_ready_i  in  1  system consumes the rx byte.
- tx_data_i  in  DATA_W  byte for the host.
- tx_valid_i  in  1  tx byte offered.
- tx_ready_o  out  1  tx holding register empty.
- overrun_o  out  1  sticky: host write was dropped.

Behaviour:
- Synchronization
  - All jtag_* inputs pass through SYNC_STAGES flops.
  - tck rising edge is detected on the synchronized copy. tdi is sampled from the synchronized copy in the same cycle as the edge.
  - capture and update are edge-detected (rising) on their synchronized copies.
- Reset
  - rst_n_i low at a clk edge clears: sr=0, tdo=0, rx_valid=0, rx_data=0, tx_full=0 (tx_ready_o=1), overrun=0, FSM=IDLE.
  - A synchronized jtag_reset_i high has the same effect, including mid-operation.
- FSM states: IDLE, CAPT, SHIFT, UPD.
  - IDLE -> CAPT on capture rise.
  - CAPT (one cycle) -> SHIFT.
  - SHIFT -> UPD on update rise.
  - UPD (one cycle) -> IDLE.
  - Capture rise in any state forces CAPT; the pending shift is discarded and no update occurs.
  - Update rise in IDLE or CAPT is ignored.
- Capture: sr <= {tx_buf, overrun, rx_valid, tx_full}. DR layout is sr[CMD_W-1:0]=cmd/status and sr[DR-1:CMD_W]=data.
- Shift: on each detected tck rise with synchronized shift high, sr <= {tdi, sr[DR-1:1]}. jtag_tdo_o <= new sr[0] one clk later. The shift count is not checked.
- Update: decode sr[CMD_W-1:0] in the UPD cycle.
  - 0 NOP: no effect.
  - 1 WRITE
    - If rx slot free: rx_data <= data field, rx_valid=1.
    - If rx slot full: overrun=1 and rx_data is unchanged.
    - If rx_valid&rx_ready_i in the same cycle, the slot counts as free: write is accepted, no overrun.
  - 2 READ_ACK: tx_full=0. tx_ready_o rises the next cycle.
  - 3 CLR_OVR: overrun=0.
  - 4..7: NOP.
- rx handshake: rx_valid&rx_ready_i clears rx_valid the same edge. rx_data_o holds its value until the next write.
- tx handshake: tx_valid_i&tx_ready_o loads tx_buf and sets tx_full. tx_ready_o = ~tx_full.
- Latency: a host write becomes visible on rx_valid_o SYNC_STAGES+2 clks after update rises at the pins.

Decomposition:
- Shared package jtag_dr_pkg holds:
  - the command constants (NOP=0, WRITE=1, READ_ACK=2, CLR_OVR=3);
  - the status bit indices (TX_FULL=0, RX_VALID=1, OVR=2);
  - the FSM state type.
- Natural sub-module: jtag_sync_edge, a SYNC_STAGES synchronizer with rising-edge pulse output, instantiated for tck, capture and update. Plain synchronizer use for shift, tdi and reset.

Test Plan:
- Reset: hold rst_n_i low 3 clks -> rx_valid_o=0, tx_ready_o=1, overrun_o=0, jtag_tdo_o=0.
- Host write: capture, shift 11 bits {0xA5,3'b001} LSB first, update -> rx_valid_o=1, rx_data_o=0xA5; rx_ready_i pulse clears rx_valid_o.
- Host read: system sends 0x3C with tx_valid_i -> tx_ready_o=0.
  - Next scan shifts out 0x3C and status 3'b001.
  - Shifting in cmd 2 -> tx_ready_o=1 one clk after UPD.
- Overrun: two WRITEs (0x11, 0x22) with rx_ready_i=0 -> rx_data_o=0x11, overrun_o=1.
  - Next capture status bit2=1.
  - CLR_OVR -> overrun_o=0.
- Boundary: WRITE 0x55 with rx_ready_i=1 in the UPD cycle while full -> rx_data_o=0x55, rx_valid_o=1, overrun_o=0.
- Abort/reset: capture rise mid-shift -> no update action. jtag_reset_i pulse with rx_valid_o=1 -> rx_valid_o=0, tx_ready_o=1 after SYNC_STAGES+1 clks.

Source files
------------

// File: rtl/jtag_dr_pkg.sv
// Shared command codes, status bit positions and FSM state type for the
// JTAG user-DR mailbox.
package jtag_dr_pkg;

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_WRITE    = 3'd1;
  localparam logic [2:0] CMD_READ_ACK = 3'd2;
  localparam logic [2:0] CMD_CLR_OVR  = 3'd3;

  localparam logic [1:0] STAT_TX_FULL  = 2'd0;
  localparam logic [1:0] STAT_RX_VALID = 2'd1;
  localparam logic [1:0] STAT_OVR      = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPT,
    ST_SHIFT,
    ST_UPD
  } dr_state_e;

endpackage

// File: rtl/jtag_sync_edge.sv
// Multi-flop synchronizer for one TAP signal with a one-clk pulse on each
// rising edge of the synchronized copy.
module jtag_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/jtag_dr_ctrl.sv
// User JTAG data-register sequencer: oversamples the TAP strobes on the system
// clock and exposes host scans as a byte-wide rx/tx mailbox.
module jtag_dr_ctrl
  import jtag_dr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8,
  parameter int CMD_W       = 3
) (
  input  logic              clk_sys_i,
  input  logic              rst_n_i,
  input  logic              jtag_tck_i,
  input  logic              jtag_tdi_i,
  output logic              jtag_tdo_o,
  input  logic              jtag_capture_i,
  input  logic              jtag_shift_i,
  input  logic              jtag_update_i,
  input  logic              jtag_reset_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              overrun_o
);

  localparam int DR_W = DATA_W + CMD_W;

  logic tck_rise, capt_rise, upd_rise;

  jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tck (
    .clk_i  (clk_sys_i),
    .rst_n_i(rst_n_i),
    .d_i    (jtag_tck_i),
    .rise_o (tck_rise)
  );

  jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_capture (
    .clk_i  (clk_sys_i),
    .rst_n_i(rst_n_i),
    .d_i    (jtag_capture_i),
    .rise_o (capt_rise)
  );

  jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_update (
    .clk_i  (clk_sys_i),
    .rst_n_i(rst_n_i),
    .d_i    (jtag_update_i),
    .rise_o (upd_rise)
  );

  // Level-only synchronizers, same depth as tck so tdi lines up with tck_rise.
  logic [SYNC_STAGES-1:0][2:0] lvl_sync_q, lvl_sync_d;
  logic                        tdi_s, shift_s, jtag_rst_s;

  always_comb begin
    lvl_sync_d = {lvl_sync_q[SYNC_STAGES-2:0], {jtag_reset_i, jtag_shift_i, jtag_tdi_i}};
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      lvl_sync_q <= '0;
    end else begin
      lvl_sync_q <= lvl_sync_d;
    end
  end

  assign tdi_s      = lvl_sync_q[SYNC_STAGES-1][0];
  assign shift_s    = lvl_sync_q[SYNC_STAGES-1][1];
  assign jtag_rst_s = lvl_sync_q[SYNC_STAGES-1][2];

  dr_state_e         state_q, state_d;
  logic [DR_W-1:0]   sr_q, sr_d;
  logic              tdo_q, tdo_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_full_q, tx_full_d;
  logic              overrun_q, overrun_d;
  logic [CMD_W-1:0]  status;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    tdo_d      = sr_q[0];
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    overrun_d  = overrun_q;

    status                = '0;
    status[STAT_TX_FULL]  = tx_full_q;
    status[STAT_RX_VALID] = rx_valid_q;
    status[STAT_OVR]      = overrun_q;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
    if (tx_valid_i && !tx_full_q) begin
      tx_buf_d  = tx_data_i;
      tx_full_d = 1'b1;
    end

    if ((state_q == ST_CAPT || state_q == ST_SHIFT) && shift_s && tck_rise) begin
      sr_d = {tdi_s, sr_q[DR_W-1:1]};
    end

    unique case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_CAPT:  state_d = ST_SHIFT;
      ST_SHIFT: if (upd_rise) state_d = ST_UPD;
      ST_UPD: begin
        state_d = ST_IDLE;
        case (sr_q[CMD_W-1:0])
          CMD_NOP: ;
          CMD_WRITE: begin
            // A byte consumed in this same cycle frees the slot for the write.
            if (!rx_valid_q || rx_ready_i) begin
              rx_data_d  = sr_q[DR_W-1:CMD_W];
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
          CMD_READ_ACK: tx_full_d = 1'b0;
          CMD_CLR_OVR:  overrun_d = 1'b0;
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh capture always wins and discards any scan in progress.
    if (capt_rise) begin
      state_d = ST_CAPT;
      sr_d    = {tx_buf_q, status};
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i || jtag_rst_s) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      tdo_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      tdo_q      <= tdo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_full_q  <= tx_full_d;
      overrun_q  <= overrun_d;
    end
  end

  // Holding register content is only meaningful while tx_full_q is set.
  always_ff @(posedge clk_sys_i) begin
    tx_buf_q <= tx_buf_d;
  end

  assign jtag_tdo_o = tdo_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ready_o = ~tx_full_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_jtag_dr_ctrl.sv
// Directed bench for jtag_dr_ctrl with queue-based scoreboards for the rx byte
// stream and the DR contents shifted out on tdo.
`timescale 1ns/1ps
module tb_jtag_dr_ctrl;
  import jtag_dr_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int DATA_W      = 8;
  localparam int CMD_W       = 3;
  localparam int DR_W        = DATA_W + CMD_W;

  logic              clk_sys_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              jtag_tck_i = 1'b0;
  logic              jtag_tdi_i = 1'b0;
  logic              jtag_tdo_o;
  logic              jtag_capture_i = 1'b0;
  logic              jtag_shift_i = 1'b0;
  logic              jtag_update_i = 1'b0;
  logic              jtag_reset_i = 1'b0;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_ready_i = 1'b0;
  logic [DATA_W-1:0] tx_data_i = '0;
  logic              tx_valid_i = 1'b0;
  logic              tx_ready_o;
  logic              overrun_o;

  jtag_dr_ctrl #(
    .SYNC_STAGES(SYNC_STAGES),
    .DATA_W     (DATA_W),
    .CMD_W      (CMD_W)
  ) dut (
    .clk_sys_i     (clk_sys_i),
    .rst_n_i       (rst_n_i),
    .jtag_tck_i    (jtag_tck_i),
    .jtag_tdi_i    (jtag_tdi_i),
    .jtag_tdo_o    (jtag_tdo_o),
    .jtag_capture_i(jtag_capture_i),
    .jtag_shift_i  (jtag_shift_i),
    .jtag_update_i (jtag_update_i),
    .jtag_reset_i  (jtag_reset_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .tx_data_i     (tx_data_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  typedef struct packed {
    logic [DR_W-1:0] mask;
    logic [DR_W-1:0] val;
  } dr_exp_t;

  int                n_cmp = 0;
  int                n_err = 0;
  logic [DATA_W-1:0] exp_rx[$];
  dr_exp_t           exp_dr[$];
  logic [DR_W-1:0]   dr_bits = '0;
  int                dr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rx monitor: every accepted byte must match the next expected byte.
  always @(negedge clk_sys_i) begin
    if (rst_n_i && rx_valid_o && rx_ready_i) begin
      if (exp_rx.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_unexpected: got byte %0h with no byte expected", rx_data_o);
      end else begin
        chk("rx_data", rx_data_o, exp_rx.pop_front());
      end
    end
  end

  // tdo collector: bits leave LSB first, one per tck rise while shift is high.
  always @(posedge jtag_capture_i or posedge jtag_tck_i) begin
    if (jtag_capture_i) begin
      dr_bits = '0;
      dr_cnt  = 0;
    end else if (jtag_shift_i) begin
      dr_bits = {jtag_tdo_o, dr_bits[DR_W-1:1]};
      dr_cnt++;
    end
  end

  always @(posedge jtag_update_i) begin
    dr_exp_t e;
    if (exp_dr.size() != 0) begin
      e = exp_dr.pop_front();
      chk("dr_out", dr_bits & e.mask, e.val & e.mask);
      chk("dr_bitcount", dr_cnt, DR_W);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys_i);
      #2;
    end
  endtask

  task automatic scan(input logic [DR_W-1:0] din, input int nbits);
    jtag_capture_i = 1'b1;
    step(4);
    jtag_capture_i = 1'b0;
    step(6);
    jtag_shift_i = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      jtag_tdi_i = din[i];
      jtag_tck_i = 1'b0;
      step(4);
      jtag_tck_i = 1'b1;
      step(4);
    end
    jtag_tck_i = 1'b0;
    step(4);
    jtag_shift_i = 1'b0;
    step(2);
  endtask

  task automatic pulse_update();
    jtag_update_i = 1'b1;
    step(4);
    jtag_update_i = 1'b0;
    step(6);
  endtask

  initial begin
    #(20000 * 10);
    $display("FAIL watchdog: run exceeded 20000 clks, summary not reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    step(3);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_tx_ready", tx_ready_o, 1);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_tdo", jtag_tdo_o, 0);
    chk("rst_rx_data", rx_data_o, 0);
    rst_n_i = 1'b1;
    step(3);

    // Host write 0xA5, visible SYNC_STAGES+2 clks after update rises
    exp_dr.push_back('{mask: 11'h007, val: 11'h000});
    scan({8'hA5, CMD_WRITE}, DR_W);
    jtag_update_i = 1'b1;
    step(SYNC_STAGES + 1);
    chk("wr_latency_early", rx_valid_o, 0);
    step(1);
    chk("wr_latency_valid", rx_valid_o, 1);
    chk("wr_data", rx_data_o, 8'hA5);
    jtag_update_i = 1'b0;
    step(6);
    exp_rx.push_back(8'hA5);
    rx_ready_i = 1'b1;
    step(1);
    rx_ready_i = 1'b0;
    chk("wr_consumed", rx_valid_o, 0);
    chk("wr_data_hold", rx_data_o, 8'hA5);

    // Host read of 0x3C, then READ_ACK
    tx_data_i  = 8'h3C;
    tx_valid_i = 1'b1;
    step(1);
    tx_valid_i = 1'b0;
    chk("tx_loaded", tx_ready_o, 0);
    exp_dr.push_back('{mask: 11'h7FF, val: {8'h3C, 3'b001}});
    scan({8'h00, CMD_READ_ACK}, DR_W);
    jtag_update_i = 1'b1;
    step(SYNC_STAGES + 1);
    chk("ack_upd_cycle", tx_ready_o, 0);
    step(1);
    chk("ack_tx_ready", tx_ready_o, 1);
    jtag_update_i = 1'b0;
    step(6);

    // Overrun: two writes with nobody consuming
    exp_dr.push_back('{mask: 11'h7FF, val: {8'h3C, 3'b000}});
    scan({8'h11, CMD_WRITE}, DR_W);
    pulse_update();
    exp_dr.push_back('{mask: 11'h7FF, val: {8'h3C, 3'b010}});
    scan({8'h22, CMD_WRITE}, DR_W);
    pulse_update();
    chk("ovr_data_kept", rx_data_o, 8'h11);
    chk("ovr_flag", overrun_o, 1);
    chk("ovr_rx_valid", rx_valid_o, 1);
    exp_dr.push_back('{mask: 11'h7FF, val: {8'h3C, 3'b110}});
    scan({8'h00, CMD_CLR_OVR}, DR_W);
    pulse_update();
    chk("ovr_cleared", overrun_o, 0);

    // Boundary: write while full, consumer takes the old byte in the UPD cycle
    exp_rx.push_back(8'h11);
    exp_dr.push_back('{mask: 11'h7FF, val: {8'h3C, 3'b010}});
    scan({8'h55, CMD_WRITE}, DR_W);
    jtag_update_i = 1'b1;
    step(SYNC_STAGES + 1);
    rx_ready_i = 1'b1;
    step(1);
    rx_ready_i = 1'b0;
    jtag_update_i = 1'b0;
    chk("bnd_data", rx_data_o, 8'h55);
    chk("bnd_valid", rx_valid_o, 1);
    chk("bnd_no_ovr", overrun_o, 0);
    step(6);
    exp_rx.push_back(8'h55);
    rx_ready_i = 1'b1;
    step(1);
    rx_ready_i = 1'b0;
    step(2);

    // Abort: recapture mid-shift of a WRITE, then update
    scan({8'h77, CMD_WRITE}, 8);
    scan('0, 0);
    pulse_update();
    chk("abort_rx_valid", rx_valid_o, 0);
    chk("abort_overrun", overrun_o, 0);

    // TAP reset with a byte pending and tx full
    exp_dr.push_back('{mask: 11'h7FF, val: {8'h3C, 3'b000}});
    scan({8'h66, CMD_WRITE}, DR_W);
    pulse_update();
    chk("pre_trst_valid", rx_valid_o, 1);
    tx_data_i  = 8'h5A;
    tx_valid_i = 1'b1;
    step(1);
    tx_valid_i = 1'b0;
    chk("pre_trst_tx_ready", tx_ready_o, 0);
    jtag_reset_i = 1'b1;
    step(SYNC_STAGES);
    chk("trst_early_valid", rx_valid_o, 1);
    step(1);
    chk("trst_rx_valid", rx_valid_o, 0);
    chk("trst_tx_ready", tx_ready_o, 1);
    jtag_reset_i = 1'b0;
    step(6);

    chk("rx_queue_left", exp_rx.size(), 0);
    chk("dr_queue_left", exp_dr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
